matriz_2x2_packer: RTL and testbench
====================================

# matriz_2x2_packer

Serial-to-packed front end for the 2x2 matrix datapath. It accepts four signed matrix elements one per handshake in row-major order (a, b, c, d). It emits them as one packed matrix word in the layout the determinant unit consumes: a in the top byte, d in the bottom byte. A one-entry output register lets the next matrix be collected while the previous one waits on the downstream stage.

## Interface
- ELEM_W, 8, element width in bits (two's complement); matrix word width is 4*ELEM_W
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  element present on in_data
- in_ready  out  1  packer can accept an element this cycle
- in_data  in  ELEM_W  signed element
- in_first  in  1  marks element a (start of matrix); sampled only on an accepted transfer
- out_valid  out  1  packed matrix held on out_matriz
- out_ready  in  1  downstream accepts out_matriz
- out_matriz  out  4*ELEM_W  packed matrix: a=[4W-1:3W], b=[3W-1:2W], c=[2W-1:W], d=[W-1:0]
- err  out  1  one-cycle pulse on a framing error

## Operation
- Transfer on either port occurs when valid && ready on the same rising edge.
- Elements are stored bit-exact, with no sign extension or arithmetic. The downstream stage sign-extends.
- States:
  - IDLE: waiting for element a.
  - COLLECT: elements b..d expected, tracked by a 2-bit index 1..3.
  - HOLD: four elements gathered and the output register is full.
- IDLE:
  - An accepted element with in_first=1 is stored as a; go to COLLECT with index=1.
  - An accepted element with in_first=0 is dropped and err pulses.
- COLLECT:
  - An accepted element with in_first=0 is stored at the current index, and the index increments.
  - On accepting d (index 3): if the output register is empty, or is being drained this cycle (out_valid && out_ready), the assembled word loads into the output and the state goes to IDLE. Otherwise the state goes to HOLD.
  - An accepted element with in_first=1 discards the partial matrix, is stored as a new a, sets index=1, and pulses err.
- HOLD:
  - in_ready=0.
  - When out_valid && out_ready, the collected word loads into the output register on that edge and the state goes to IDLE.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD.
- Output register:
  - out_valid sets on load.
  - out_valid clears on drain unless a load happens on the same edge; a simultaneous drain and load keeps out_valid=1 with the new word.
  - out_matriz is stable while out_valid && !out_ready.
- Reset at any point, including mid-matrix or in HOLD:
  - The partial and held matrices are discarded.
  - State returns to IDLE with index=0.
  - The first accepted element after reset must carry in_first=1.

## Timing
- Reset values:
  - in_ready=1 one cycle after reset release; it is combinational from state, so it is also 1 during reset.
  - out_valid=0, out_matriz=0, err=0.
- Latency: out_valid rises on the edge that accepts d, so it is visible in the cycle after d's transfer.
- Throughput: one matrix per 4 cycles sustained with out_ready=1; no bubbles.
- With out_ready=0:
  - The first matrix fills the output register, and the second is collected fully before entering HOLD.
  - in_ready drops in the cycle after d of the second matrix is accepted.
- err is registered and asserts in the cycle after the offending transfer, for exactly one cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package matriz_pkg:
  - ELEM_W default.
  - State enum (IDLE, COLLECT, HOLD).
  - Field-position constants for a/b/c/d, so the packer and determinant unit agree on layout.
- Single module; no sub-module needed.
- Collect register and output register are separate 4*ELEM_W registers.

## Test plan
- Basic packing: send 3, -2, 5, 7 (in_first on 3), out_ready=1 -> one out_valid pulse with out_matriz=0x03FE0507, err=0.
- Back-to-back streaming: 3 matrices with in_valid held high and out_ready=1 -> out_valid at cycles 4, 8, 12 after the first transfer, in_ready never low.
- Backpressure: out_ready=0, send 2 matrices (0x01020304 then 0x05060708) -> second d accepted, then in_ready=0. Raise out_ready -> 0x01020304 then 0x05060708 delivered in order, and in_ready returns high.
- Framing errors:
  - Element 9 with in_first=0 in IDLE -> err pulse, dropped.
  - in_first mid-matrix after 2 elements -> err pulse; output is the restarted matrix, e.g. 0x7F80FF00 for 127, -128, -1, 0.
- Reset mid-operation: assert rst_n=0 after 2 elements, or while in HOLD -> out_valid=0, out_matriz=0 immediately. After release, a fresh 4-element matrix packs correctly with no stale bytes.
- Simultaneous drain and load: output full, d accepted in the same cycle out_ready=1 -> out_valid stays 1 and out_matriz changes to the new word on that edge.

Source files
------------

// File: rtl/matriz_pkg.sv
// ---------------------------------------------------------------------------
// matriz_pkg
// Shared definitions for the 2x2 matrix datapath.
//   - ELEM_W_DEFAULT : default element width (two's complement)
//   - state_e        : packer control states
//   - FIELD_A..D     : slot of each element inside the packed matrix word,
//                      counted from the LSB end. The packer and the
//                      determinant unit both derive bit positions from these.
//   - field_lsb()    : LSB bit position of a row-major element index
// ---------------------------------------------------------------------------
package matriz_pkg;

    localparam int ELEM_W_DEFAULT = 8;
    localparam int N_ELEMS        = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // a sits in the top slot, d in the bottom slot.
    localparam int FIELD_A = 3;
    localparam int FIELD_B = 2;
    localparam int FIELD_C = 1;
    localparam int FIELD_D = 0;

    // idx is the row-major position: 0=a, 1=b, 2=c, 3=d.
    function automatic int field_lsb(input logic [1:0] idx, input int elem_w);
        return (FIELD_A - int'(idx)) * elem_w;
    endfunction

endpackage

// File: rtl/matriz_2x2_packer_if.sv
// ---------------------------------------------------------------------------
// matriz_2x2_packer_if
// Element input stream, packed matrix output stream and error flag of the
// 2x2 packer.
//   in_valid/in_ready/in_data/in_first : one signed element per transfer
//   out_valid/out_ready/out_matriz     : one packed 4*ELEM_W matrix word
//   err                                : one-cycle framing error pulse
// Modports:
//   slave  : the packer
//   master : the surrounding logic (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface matriz_2x2_packer_if #(
    parameter int ELEM_W = matriz_pkg::ELEM_W_DEFAULT
);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [ELEM_W-1:0] in_data;
    logic                    in_first;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*ELEM_W-1:0]     out_matriz;
    logic                    err;

    modport slave (
        input  in_valid, in_data, in_first, out_ready,
        output in_ready, out_valid, out_matriz, err
    );

    modport master (
        output in_valid, in_data, in_first, out_ready,
        input  in_ready, out_valid, out_matriz, err
    );

endinterface

// File: rtl/matriz_2x2_packer.sv
// ---------------------------------------------------------------------------
// matriz_2x2_packer
// Collects four signed elements (a, b, c, d in row-major order, a flagged by
// in_first) and presents them as one packed word: a=[4W-1:3W] .. d=[W-1:0].
// Elements are stored bit-exact. A one-entry output register lets the next
// matrix be collected while the previous one waits downstream.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : matriz_2x2_packer_if.slave (element in, matrix out, err)
// ---------------------------------------------------------------------------
module matriz_2x2_packer
    import matriz_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matriz_2x2_packer_if.slave   bus
);

    localparam int MAT_W = 4 * ELEM_W;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [MAT_W-1:0]   coll_q, coll_d;
    logic [MAT_W-1:0]   out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               err_q, err_d;

    logic               in_ready;
    logic               in_fire;
    logic               drain;
    logic               load;
    logic [MAT_W-1:0]   load_word;

    function automatic logic [MAT_W-1:0] put_elem(
        input logic [MAT_W-1:0]  word,
        input logic [1:0]        idx,
        input logic [ELEM_W-1:0] elem
    );
        logic [MAT_W-1:0] w;
        w = word;
        w[field_lsb(idx, ELEM_W) +: ELEM_W] = elem;
        return w;
    endfunction

    // Ready depends on registered state only, never on in_valid.
    assign in_ready = (state_q != ST_HOLD);
    assign in_fire  = bus.in_valid && in_ready;
    assign drain    = out_vld_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        coll_d    = coll_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_word = coll_q;

        if (drain) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (bus.in_first) begin
                        coll_d  = put_elem(coll_q, 2'd0, bus.in_data);
                        idx_d   = 2'd1;
                        state_d = ST_COLLECT;
                    end else begin
                        // Orphan element without a start marker is dropped.
                        err_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (in_fire) begin
                    if (bus.in_first) begin
                        // Restart: the new element becomes a; stale b..d
                        // bytes are overwritten before the word is used.
                        coll_d = put_elem(coll_q, 2'd0, bus.in_data);
                        idx_d  = 2'd1;
                        err_d  = 1'b1;
                    end else begin
                        coll_d = put_elem(coll_q, idx_q, bus.in_data);
                        if (idx_q == 2'd3) begin
                            idx_d = 2'd0;
                            // Load directly when the output slot is free or
                            // frees up on this very edge.
                            if (!out_vld_q || drain) begin
                                load      = 1'b1;
                                load_word = coll_d;
                                state_d   = ST_IDLE;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (drain) begin
                    load      = 1'b1;
                    load_word = coll_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase

        if (load) begin
            out_d     = load_word;
            out_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
        end
    end

    // Collect register needs no reset: every slot is written before a
    // word built from it can reach the output.
    always_ff @(posedge clk) begin
        coll_q <= coll_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_vld_q;
    assign bus.out_matriz = out_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_matriz_2x2_packer.sv
// ---------------------------------------------------------------------------
// tb_matriz_2x2_packer
// Directed stimulus with a behavioural scoreboard: a list of received
// elements, a queue of expected packed words, and per-cycle checks of the
// DUT outputs against them, plus literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_matriz_2x2_packer;
    import matriz_pkg::*;

    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matriz_2x2_packer_if #(.ELEM_W(EW)) bus ();

    matriz_2x2_packer #(.ELEM_W(EW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int          part[$];
    logic [31:0] exp_q[$];
    logic [31:0] drain_log[$];
    int unsigned drain_cyc[$];
    int unsigned xfer_cyc[$];
    logic        err_pend   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;
    int          ir_low_cnt = 0;

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return 32'(((a & 255) << 24) | ((b & 255) << 16) | ((c & 255) << 8) | (d & 255));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Per-cycle monitor: outputs are settled at the falling edge, and the
    // inputs seen here are the ones the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                part.delete();
                exp_q.delete();
                err_pend   = 1'b0;
                prev_stall = 1'b0;
                chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
                chk("rst_out_matriz", bus.out_matriz, 32'd0);
                chk("rst_err",        32'(bus.err), 32'd0);
                chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
            end else begin
                chk("err", 32'(bus.err), 32'(err_pend));
                if (prev_stall) chk("stall_word", bus.out_matriz, prev_word);
                chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() < 2));
                if (!bus.in_ready) ir_low_cnt++;
                if (bus.out_valid && exp_q.size() > 0) chk("out_matriz", bus.out_matriz, exp_q[0]);
                if (bus.out_valid && bus.out_ready) begin
                    drain_log.push_back(bus.out_matriz);
                    drain_cyc.push_back(cyc + 1);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_word  = bus.out_matriz;
                err_pend   = 1'b0;
                if (bus.in_valid && bus.in_ready) begin
                    xfer_cyc.push_back(cyc + 1);
                    if (bus.in_first) begin
                        err_pend = (part.size() != 0);
                        part.delete();
                        part.push_back(int'(bus.in_data));
                    end else if (part.size() == 0) begin
                        err_pend = 1'b1;
                    end else begin
                        part.push_back(int'(bus.in_data));
                        if (part.size() == 4) begin
                            exp_q.push_back(pack4(part[0], part[1], part[2], part[3]));
                            part.delete();
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int d, input logic f);
        bit done;
        done = 1'b0;
        bus.in_data  = 8'(d);
        bus.in_first = f;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_mat(input int a, input int b, input int c, input int d);
        send(a, 1'b1);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_imm_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_imm_matriz", bus.out_matriz, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int db;
        int xb;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pin the model's packing against hand-computed words
        chk("model_pack_basic",   pack4(3, -2, 5, 7),       32'h03FE0507);
        chk("model_pack_restart", pack4(127, -128, -1, 0),  32'h7F80FF00);

        // Basic packing
        db = drain_log.size();
        send_mat(3, -2, 5, 7);
        idle();
        wait_cycles(3);
        chk("basic_count", 32'(drain_log.size() - db), 32'd1);
        if (drain_log.size() > db) chk("basic_word", drain_log[db], 32'h03FE0507);

        // Back-to-back streaming
        xb = xfer_cyc.size();
        db = drain_cyc.size();
        ir_low_cnt = 0;
        for (int m = 0; m < 3; m++) send_mat(m*4 + 1, m*4 + 2, m*4 + 3, m*4 + 4);
        idle();
        wait_cycles(6);
        for (int k = 0; k < 3; k++) begin
            if (drain_cyc.size() > db + k && xfer_cyc.size() > xb)
                chk("stream_latency", 32'(drain_cyc[db+k] - xfer_cyc[xb]), 32'(4*(k+1)));
            else
                chk("stream_missing", 32'(drain_cyc.size()), 32'(db + k + 1));
        end
        chk("stream_in_ready_low", 32'(ir_low_cnt), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        db = drain_log.size();
        send_mat(1, 2, 3, 4);
        send_mat(5, 6, 7, 8);
        chk("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
        idle();
        wait_cycles(3);
        chk("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
        chk("bp_out_matriz",    bus.out_matriz, 32'h01020304);
        bus.out_ready = 1'b1;
        wait_cycles(4);
        chk("bp_count", 32'(drain_log.size() - db), 32'd2);
        if (drain_log.size() > db + 1) begin
            chk("bp_word0", drain_log[db],   32'h01020304);
            chk("bp_word1", drain_log[db+1], 32'h05060708);
        end
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Framing errors
        db = drain_log.size();
        send(9, 1'b0);
        chk("idle_orphan_err", 32'(bus.err), 32'd1);
        send(1, 1'b1);
        chk("err_one_cycle", 32'(bus.err), 32'd0);
        send(2, 1'b0);
        send(127, 1'b1);
        chk("restart_err", 32'(bus.err), 32'd1);
        send(-128, 1'b0);
        send(-1, 1'b0);
        send(0, 1'b0);
        idle();
        wait_cycles(3);
        chk("restart_count", 32'(drain_log.size() - db), 32'd1);
        if (drain_log.size() > db) chk("restart_word", drain_log[db], 32'h7F80FF00);

        // Reset mid-matrix
        send(1, 1'b1);
        send(2, 1'b0);
        do_reset();
        db = drain_log.size();
        send_mat(8'h11, 8'h22, 8'h33, 8'h44);
        idle();
        wait_cycles(3);
        chk("rst_mid_count", 32'(drain_log.size() - db), 32'd1);
        if (drain_log.size() > db) chk("rst_mid_word", drain_log[db], 32'h11223344);

        // Reset while in HOLD
        bus.out_ready = 1'b0;
        send_mat(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        send_mat(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        do_reset();
        bus.out_ready = 1'b1;
        db = drain_log.size();
        send_mat(8'h55, 8'h66, 8'h77, 8'h88);
        idle();
        wait_cycles(3);
        chk("rst_hold_count", 32'(drain_log.size() - db), 32'd1);
        if (drain_log.size() > db) chk("rst_hold_word", drain_log[db], 32'h55667788);

        // Simultaneous drain and load
        bus.out_ready = 1'b0;
        db = drain_log.size();
        send_mat(8'h10, 8'h20, 8'h30, 8'h40);
        send(8'h50, 1'b1);
        send(8'h60, 1'b0);
        send(8'h70, 1'b0);
        bus.out_ready = 1'b1;
        send(8'h80, 1'b0);
        chk("sim_out_valid", 32'(bus.out_valid), 32'd1);
        chk("sim_out_word",  bus.out_matriz, 32'h50607080);
        idle();
        wait_cycles(3);
        chk("sim_count", 32'(drain_log.size() - db), 32'd2);
        if (drain_log.size() > db + 1) begin
            chk("sim_word0", drain_log[db],   32'h10203040);
            chk("sim_word1", drain_log[db+1], 32'h50607080);
        end

        wait_cycles(2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_out_valid",   32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
